// File: rtl/cache_arb_pkg.sv
// Shared encodings and default widths for the two-port cache request arbiter.
package cache_arb_pkg;

    localparam int unsigned DEF_ADDR_SIZE = 16;
    localparam int unsigned DEF_WORD_SIZE = 32;
    localparam int unsigned BVAL_SIZE     = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT
    } arb_state_e;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } req_type_e;

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Requester-side and cache-side signal bundle of the cache port arbiter.
interface cache_port_arbiter_if
    import cache_arb_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int unsigned WORD_SIZE = DEF_WORD_SIZE
);

    logic [ADDR_SIZE-1:0] req0_addr,  req1_addr;
    logic [WORD_SIZE-1:0] req0_wdata, req1_wdata;
    logic [BVAL_SIZE-1:0] req0_bval,  req1_bval;
    logic                 req0_rd,    req1_rd;
    logic                 req0_wr,    req1_wr;
    logic                 req0_ack,   req1_ack;
    logic [WORD_SIZE-1:0] req0_rdata, req1_rdata;

    logic [ADDR_SIZE-1:0] cache_addr;
    logic [WORD_SIZE-1:0] cache_wdata;
    logic [BVAL_SIZE-1:0] cache_bval;
    logic                 cache_rd;
    logic                 cache_wr;
    logic                 cache_ack;
    logic [WORD_SIZE-1:0] cache_rdata;

    logic                 busy;
    logic                 arb_timeout;

    modport slave (
        input  req0_addr, req1_addr, req0_wdata, req1_wdata, req0_bval, req1_bval,
        input  req0_rd, req1_rd, req0_wr, req1_wr,
        input  cache_ack, cache_rdata,
        output req0_ack, req1_ack, req0_rdata, req1_rdata,
        output cache_addr, cache_wdata, cache_bval, cache_rd, cache_wr,
        output busy, arb_timeout
    );

    modport master (
        output req0_addr, req1_addr, req0_wdata, req1_wdata, req0_bval, req1_bval,
        output req0_rd, req1_rd, req0_wr, req1_wr,
        output cache_ack, cache_rdata,
        input  req0_ack, req1_ack, req0_rdata, req1_rdata,
        input  cache_addr, cache_wdata, cache_bval, cache_rd, cache_wr,
        input  busy, arb_timeout
    );

endinterface

// File: rtl/cache_req_slot.sv
// One-deep capture register for a requester: latches a rd/wr pulse and holds it
// pending until the arbiter completes it.
module cache_req_slot
    import cache_arb_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int unsigned WORD_SIZE = DEF_WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd,
    input  logic                 wr,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic [BVAL_SIZE-1:0] bval,
    input  logic                 clear,
    output logic                 pending,
    output logic [ADDR_SIZE-1:0] held_addr,
    output logic [WORD_SIZE-1:0] held_wdata,
    output logic [BVAL_SIZE-1:0] held_bval,
    output req_type_e            held_type
);

    // A pulse arriving while the slot is occupied is dropped; wr beats rd.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= 1'b0;
            held_addr  <= '0;
            held_wdata <= '0;
            held_bval  <= '0;
            held_type  <= RD;
        end else if (clear) begin
            pending <= 1'b0;
        end else if (!pending && (rd || wr)) begin
            pending    <= 1'b1;
            held_addr  <= addr;
            held_wdata <= wdata;
            held_bval  <= bval;
            held_type  <= wr ? WR : RD;
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter serialising fetch (port 0) and load/store (port 1) requests
// onto one cache port. Optional WAIT watchdog enabled by CACHE_ARB_TIMEOUT_EN.
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned ADDR_SIZE      = DEF_ADDR_SIZE,
    parameter int unsigned WORD_SIZE      = DEF_WORD_SIZE,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                 cache_clk,
    input logic                 cache_reset,
    cache_port_arbiter_if.slave bus
);

    logic                 pend0, pend1, clear0, clear1;
    logic [ADDR_SIZE-1:0] s0_addr, s1_addr;
    logic [WORD_SIZE-1:0] s0_wdata, s1_wdata;
    logic [BVAL_SIZE-1:0] s0_bval, s1_bval;
    req_type_e            s0_type, s1_type;

    cache_req_slot #(.ADDR_SIZE(ADDR_SIZE), .WORD_SIZE(WORD_SIZE)) u_slot0 (
        .clk(cache_clk), .rst(cache_reset),
        .rd(bus.req0_rd), .wr(bus.req0_wr), .addr(bus.req0_addr),
        .wdata(bus.req0_wdata), .bval(bus.req0_bval), .clear(clear0),
        .pending(pend0), .held_addr(s0_addr), .held_wdata(s0_wdata),
        .held_bval(s0_bval), .held_type(s0_type)
    );

    cache_req_slot #(.ADDR_SIZE(ADDR_SIZE), .WORD_SIZE(WORD_SIZE)) u_slot1 (
        .clk(cache_clk), .rst(cache_reset),
        .rd(bus.req1_rd), .wr(bus.req1_wr), .addr(bus.req1_addr),
        .wdata(bus.req1_wdata), .bval(bus.req1_bval), .clear(clear1),
        .pending(pend1), .held_addr(s1_addr), .held_wdata(s1_wdata),
        .held_bval(s1_bval), .held_type(s1_type)
    );

    arb_state_e           state;
    logic                 grant, last_grant;
    logic                 rd_strobe, wr_strobe, ack0, ack1, busy_r;
    logic [ADDR_SIZE-1:0] out_addr;
    logic [WORD_SIZE-1:0] out_wdata, rdata0, rdata1;
    logic [BVAL_SIZE-1:0] out_bval;

    logic                 any_pend, both_pend, pick, take_ack, expire, done;
    logic [ADDR_SIZE-1:0] sel_addr;
    logic [WORD_SIZE-1:0] sel_wdata, ret_data;
    logic [BVAL_SIZE-1:0] sel_bval;
    req_type_e            sel_type;

    // Grant selection: on contention the port that did not win last time goes next.
    always_comb begin
        any_pend  = pend0 | pend1;
        both_pend = pend0 & pend1;
        pick      = both_pend ? ~last_grant : pend1;
        sel_addr  = pick ? s1_addr  : s0_addr;
        sel_wdata = pick ? s1_wdata : s0_wdata;
        sel_bval  = pick ? s1_bval  : s0_bval;
        sel_type  = pick ? s1_type  : s0_type;
        take_ack  = (state != IDLE) && bus.cache_ack;
        done      = take_ack | expire;
        ret_data  = expire ? '0 : bus.cache_rdata;
        clear0    = done & ~grant;
        clear1    = done & grant;
    end

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_r;

    // A cache_ack in the expiry cycle wins, so expiry requires no ack.
    assign expire = (state == WAIT) && !bus.cache_ack &&
                    (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge cache_clk) begin
        if (cache_reset) begin
            wait_cnt  <= '0;
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= expire;
            if (state == ISSUE)
                wait_cnt <= '0;
            else if (state == WAIT)
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign bus.arb_timeout = timeout_r;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign expire             = 1'b0;
    assign bus.arb_timeout    = 1'b0;
`endif

    // IDLE -> ISSUE -> WAIT -> IDLE; completion returns to IDLE from ISSUE or WAIT.
    always_ff @(posedge cache_clk) begin
        if (cache_reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            rd_strobe  <= 1'b0;
            wr_strobe  <= 1'b0;
            out_addr   <= '0;
            out_wdata  <= '0;
            out_bval   <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            busy_r     <= 1'b0;
        end else begin
            rd_strobe <= 1'b0;
            wr_strobe <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            if (done) begin
                state  <= IDLE;
                busy_r <= 1'b0;
                if (grant) begin
                    ack1   <= 1'b1;
                    rdata1 <= ret_data;
                end else begin
                    ack0   <= 1'b1;
                    rdata0 <= ret_data;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (any_pend) begin
                            state     <= ISSUE;
                            busy_r    <= 1'b1;
                            grant     <= pick;
                            rd_strobe <= (sel_type == RD);
                            wr_strobe <= (sel_type == WR);
                            out_addr  <= sel_addr;
                            out_wdata <= sel_wdata;
                            out_bval  <= sel_bval;
                            if (both_pend)
                                last_grant <= pick;
                        end
                    end
                    ISSUE:   state <= WAIT;
                    WAIT:    state <= WAIT;
                    default: begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.cache_rd    = rd_strobe;
    assign bus.cache_wr    = wr_strobe;
    assign bus.cache_addr  = out_addr;
    assign bus.cache_wdata = out_wdata;
    assign bus.cache_bval  = out_bval;
    assign bus.req0_ack    = ack0;
    assign bus.req1_ack    = ack1;
    assign bus.req0_rdata  = rdata0;
    assign bus.req1_rdata  = rdata1;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Self-checking bench for cache_port_arbiter: vector table plus scoreboarded
// cache strobes and requester acks; timeout case follows CACHE_ARB_TIMEOUT_EN.
module tb_cache_port_arbiter;

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_port_arbiter_if #(.ADDR_SIZE(16), .WORD_SIZE(32)) bus ();

    cache_port_arbiter #(.ADDR_SIZE(16), .WORD_SIZE(32), .TIMEOUT_CYCLES(TMO)) dut (
        .cache_clk(clk), .cache_reset(rst), .bus(bus)
    );

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bval;
    } issue_t;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          tmo;
    } ack_t;

    typedef struct {
        bit          port;
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bval;
        logic [31:0] rdata;
        int          dly;
        bit          exp_wr;
    } vec_t;

    issue_t iss_q[$];
    ack_t   ack_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit port, input bit rd, input bit wr, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        if (port) begin
            bus.req1_rd = rd; bus.req1_wr = wr; bus.req1_addr = a;
            bus.req1_wdata = d; bus.req1_bval = b;
        end else begin
            bus.req0_rd = rd; bus.req0_wr = wr; bus.req0_addr = a;
            bus.req0_wdata = d; bus.req0_bval = b;
        end
    endtask

    task automatic quiet();
        bus.req0_rd = 1'b0; bus.req0_wr = 1'b0;
        bus.req1_rd = 1'b0; bus.req1_wr = 1'b0;
    endtask

    task automatic exp_issue(input bit wr, input logic [15:0] a, input logic [31:0] d,
                             input logic [3:0] b);
        issue_t e;
        e.wr = wr; e.addr = a; e.wdata = d; e.bval = b;
        iss_q.push_back(e);
    endtask

    task automatic exp_ack(input bit port, input logic [31:0] r, input bit tmo);
        ack_t e;
        e.port = port; e.rdata = r; e.tmo = tmo;
        ack_q.push_back(e);
    endtask

    // Wait (bounded) for a cache strobe, then ack it dly cycles later.
    task automatic serve(input logic [31:0] r, input int dly, output int s_cyc, output int a_cyc);
        for (int i = 0; i < 20 && !(bus.cache_rd || bus.cache_wr); i++) step();
        chk("serve_strobe_seen", 32'(bus.cache_rd || bus.cache_wr), 1);
        s_cyc = cyc;
        repeat (dly) step();
        bus.cache_ack = 1'b1; bus.cache_rdata = r;
        a_cyc = cyc;
        step();
        bus.cache_ack = 1'b0; bus.cache_rdata = $urandom;
    endtask

    // Scoreboard monitors sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cache_rd || bus.cache_wr) begin
                chk("issue_expected", 32'(iss_q.size() != 0), 1);
                chk("issue_rd_wr_excl", 32'(bus.cache_rd & bus.cache_wr), 0);
                if (iss_q.size() != 0) begin
                    issue_t e;
                    e = iss_q.pop_front();
                    chk("issue_wr", 32'(bus.cache_wr), 32'(e.wr));
                    chk("issue_addr", 32'(bus.cache_addr), 32'(e.addr));
                    chk("issue_wdata", bus.cache_wdata, e.wdata);
                    chk("issue_bval", 32'(bus.cache_bval), 32'(e.bval));
                end
            end
            if (bus.req0_ack || bus.req1_ack) begin
                chk("ack_expected", 32'(ack_q.size() != 0), 1);
                chk("ack_one_hot", 32'(bus.req0_ack & bus.req1_ack), 0);
                if (ack_q.size() != 0) begin
                    ack_t e;
                    e = ack_q.pop_front();
                    chk("ack_port", 32'(bus.req1_ack), 32'(e.port));
                    chk("ack_rdata", e.port ? bus.req1_rdata : bus.req0_rdata, e.rdata);
                    chk("ack_timeout_flag", 32'(bus.arb_timeout), 32'(e.tmo));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   s1, a1, s2, a2, lows, st;

        vecs[0] = '{0, 1, 0, 16'h0040, 32'h0,        4'hF, 32'hDEADBEEF, 3, 0};
        vecs[1] = '{1, 0, 1, 16'h1234, 32'hCAFEF00D, 4'h3, 32'h11111111, 0, 1};
        vecs[2] = '{1, 1, 1, 16'h2222, 32'hA5A5A5A5, 4'hF, 32'h22222222, 1, 1};
        vecs[3] = '{0, 0, 1, 16'h8001, 32'h0BADF00D, 4'h1, 32'h33333333, 1, 1};
        vecs[4] = '{1, 1, 0, 16'hFFFF, 32'h55555555, 4'h8, 32'hFFFFFFFF, 5, 0};
        vecs[5] = '{0, 1, 0, 16'h0000, 32'h77777777, 4'h0, 32'h00000000, 2, 0};

        rst = 1'b1;
        quiet();
        pulse(0, 0, 0, 16'h0, 32'h0, 4'h0);
        pulse(1, 0, 0, 16'h0, 32'h0, 4'h0);
        bus.cache_ack = 1'b0; bus.cache_rdata = 32'h0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_strobes", 32'({bus.cache_rd, bus.cache_wr}), 0);
        chk("rst_acks", 32'({bus.req0_ack, bus.req1_ack}), 0);
        chk("rst_addr", 32'(bus.cache_addr), 0);
        chk("rst_rdata0", bus.req0_rdata, 0);
        chk("rst_timeout", 32'(bus.arb_timeout), 0);

        // Stale ack while idle must be ignored.
        bus.cache_ack = 1'b1; bus.cache_rdata = 32'h99999999;
        step();
        bus.cache_ack = 1'b0;
        step();
        chk("stale_ack_busy", 32'(bus.busy), 0);
        chk("stale_ack_rdata1", bus.req1_rdata, 0);

        foreach (vecs[k]) begin
            pulse(vecs[k].port, vecs[k].rd, vecs[k].wr, vecs[k].addr, vecs[k].wdata, vecs[k].bval);
            exp_issue(vecs[k].exp_wr, vecs[k].addr, vecs[k].wdata, vecs[k].bval);
            exp_ack(vecs[k].port, vecs[k].rdata, 0);
            step();
            quiet();
            chk("vec_idle_at_n1", 32'(bus.busy | bus.cache_rd | bus.cache_wr), 0);
            step();
            chk("vec_strobe_at_n2", 32'({bus.cache_wr, bus.cache_rd}),
                vecs[k].exp_wr ? 32'h2 : 32'h1);
            chk("vec_busy_issue", 32'(bus.busy), 1);
            repeat (vecs[k].dly) step();
            bus.cache_ack = 1'b1; bus.cache_rdata = vecs[k].rdata;
            step();
            bus.cache_ack = 1'b0; bus.cache_rdata = $urandom;
            chk("vec_ack_pulse", 32'(vecs[k].port ? bus.req1_ack : bus.req0_ack), 1);
            chk("vec_busy_done", 32'(bus.busy), 0);
            step();
            chk("vec_ack_single", 32'({bus.req0_ack, bus.req1_ack}), 0);
            chk("vec_rdata_hold", vecs[k].port ? bus.req1_rdata : bus.req0_rdata, vecs[k].rdata);
        end

        // Contention right after reset: port 0 first, then port 1; repeat pair flips.
        rst = 1'b1; step(); rst = 1'b0; step();
        pulse(0, 1, 0, 16'h0100, 32'h0, 4'hF);
        pulse(1, 0, 1, 16'h0200, 32'h12345678, 4'hF);
        exp_issue(0, 16'h0100, 32'h0, 4'hF);
        exp_issue(1, 16'h0200, 32'h12345678, 4'hF);
        exp_ack(0, 32'hA0A0A0A0, 0);
        exp_ack(1, 32'hB1B1B1B1, 0);
        step();
        quiet();
        serve(32'hA0A0A0A0, 2, s1, a1);
        serve(32'hB1B1B1B1, 0, s2, a2);
        chk("b2b_gap", 32'(s2 - a1), 2);
        step();
        pulse(0, 1, 0, 16'h0110, 32'h0, 4'hC);
        pulse(1, 0, 1, 16'h0210, 32'h87654321, 4'h5);
        exp_issue(1, 16'h0210, 32'h87654321, 4'h5);
        exp_issue(0, 16'h0110, 32'h0, 4'hC);
        exp_ack(1, 32'hC2C2C2C2, 0);
        exp_ack(0, 32'hD3D3D3D3, 0);
        step();
        quiet();
        serve(32'hC2C2C2C2, 1, s1, a1);
        serve(32'hD3D3D3D3, 1, s2, a2);
        step();

        // Pulse during a pending slot is dropped; pulse in the ack cycle is accepted.
        pulse(0, 1, 0, 16'h0300, 32'h0, 4'hF);
        exp_issue(0, 16'h0300, 32'h0, 4'hF);
        exp_ack(0, 32'hE4E4E4E4, 0);
        step(); quiet();
        step(); step();
        pulse(0, 0, 1, 16'h0400, 32'hBAD0BAD0, 4'h2);
        step(); quiet();
        bus.cache_ack = 1'b1; bus.cache_rdata = 32'hE4E4E4E4;
        step();
        bus.cache_ack = 1'b0;
        chk("seq_ack_cycle", 32'(bus.req0_ack), 1);
        pulse(0, 1, 0, 16'h0500, 32'h0, 4'h6);
        exp_issue(0, 16'h0500, 32'h0, 4'h6);
        exp_ack(0, 32'hF5F5F5F5, 0);
        step(); quiet();
        serve(32'hF5F5F5F5, 0, s1, a1);
        step();

        // Reset in WAIT abandons the access; a later ack is ignored.
        pulse(1, 1, 0, 16'h0600, 32'h0, 4'hF);
        exp_issue(0, 16'h0600, 32'h0, 4'hF);
        step(); quiet();
        step(); step();
        chk("mid_rst_in_wait", 32'(bus.busy), 1);
        rst = 1'b1; step(); rst = 1'b0;
        step(); step();
        bus.cache_ack = 1'b1; bus.cache_rdata = 32'h66666666;
        step();
        bus.cache_ack = 1'b0;
        step(); step();
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_strobes", 32'({bus.cache_rd, bus.cache_wr}), 0);
        chk("mid_rst_addr", 32'(bus.cache_addr), 0);
        chk("mid_rst_wdata", bus.cache_wdata, 0);
        chk("mid_rst_bval", 32'(bus.cache_bval), 0);
        chk("mid_rst_rdata0", bus.req0_rdata, 0);
        chk("mid_rst_rdata1", bus.req1_rdata, 0);

        // No ack from the cache: watchdog expiry or unbounded wait.
        pulse(0, 1, 0, 16'h0700, 32'h0, 4'hF);
        exp_issue(0, 16'h0700, 32'h0, 4'hF);
        step(); quiet();
        step();
        chk("tmo_strobe", 32'(bus.cache_rd), 1);
        st = cyc;
`ifdef CACHE_ARB_TIMEOUT_EN
        exp_ack(0, 32'h0, 1);
        for (int i = 0; i < 40 && !bus.req0_ack; i++) step();
        chk("tmo_ack_seen", 32'(bus.req0_ack), 1);
        chk("tmo_latency", 32'(cyc - st), 32'(TMO + 1));
        chk("tmo_pulse", 32'(bus.arb_timeout), 1);
        step();
        chk("tmo_pulse_single", 32'(bus.arb_timeout), 0);
        chk("tmo_busy_done", 32'(bus.busy), 0);
`else
        lows = 0;
        repeat (300) begin
            step();
            if (!bus.busy) lows++;
        end
        chk("wait_busy_held", 32'(lows), 0);
        chk("wait_no_timeout", 32'(bus.arb_timeout), 0);
        rst = 1'b1; step(); rst = 1'b0; step();
`endif
        step();
        chk("iss_q_drained", 32'(iss_q.size()), 0);
        chk("ack_q_drained", 32'(ack_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
